// File: rtl/heap_pkg.sv
// Shared types and compare helper for the pipelined heap sorter.
// Define HEAP_MAX_EN to build a max-heap; the default build is a min-heap.
package heap_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CMP  = 2'd2,
    SEND = 2'd3
  } heap_state_e;

  localparam int HEAP_DATA_WIDTH = 32;
  localparam int HEAP_ADDR_WIDTH = 5;
  localparam int HEAP_CMP_WIDTH  = 64;

  // True when key a must sit above key b in the heap; equal keys never reorder.
  function automatic logic heap_before(input logic [HEAP_CMP_WIDTH-1:0] a,
                                       input logic [HEAP_CMP_WIDTH-1:0] b);
`ifdef HEAP_MAX_EN
    return (a > b);
`else
    return (a < b);
`endif
  endfunction

endpackage

// File: rtl/heap_insert_stage.sv
// Per-level insertion engine: reads the resident node on RAM port A, keeps the winner
// and forwards the loser down the leaf path. HEAP_MAX_EN selects max-heap ordering.
module heap_insert_stage
  import heap_pkg::*;
#(
  parameter int DATA_WIDTH = HEAP_DATA_WIDTH,
  parameter int ADDR_WIDTH = HEAP_ADDR_WIDTH,
  parameter int LEVEL      = 1,
  parameter int PATH_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic [PATH_WIDTH-1:0]   in_path,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [ADDR_WIDTH-1:0]   out_addr,
  output logic [PATH_WIDTH-1:0]   out_path,
  output logic [ADDR_WIDTH-1:0]   ram_addr_a,
  output logic                    ram_we_a,
  output logic [DATA_WIDTH-1:0]   ram_data_a,
  input  logic [DATA_WIDTH-1:0]   ram_q_a,
  output logic [(1<<LEVEL)-1:0]   occupied
);

  localparam int              NODES     = 1 << LEVEL;
  localparam [ADDR_WIDTH-1:0] NODE_MASK = ADDR_WIDTH'(NODES - 1);

  heap_state_e             r_state, w_state_next;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [PATH_WIDTH-1:0]   r_path;
  logic [ADDR_WIDTH-1:0]   r_ram_addr;
  logic                    r_out_valid;
  logic [DATA_WIDTH-1:0]   r_out_data;
  logic [ADDR_WIDTH-1:0]   r_out_addr;
  logic [PATH_WIDTH-1:0]   r_out_path;
  logic [NODES-1:0]        r_occupied;

  logic [NODES-1:0]        w_occ_onehot;
  logic                    w_occ_hit;
  logic                    w_we;
  logic                    w_fwd;
  logic                    w_set_occ;
  logic [DATA_WIDTH-1:0]   w_fwd_data;
  logic                    w_accept;

  assign w_accept   = (r_state == IDLE) && in_valid;
  assign in_ready   = (r_state == IDLE);
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_addr   = r_out_addr;
  assign out_path   = r_out_path;
  assign ram_addr_a = r_ram_addr;
  assign ram_we_a   = w_we;
  assign ram_data_a = r_data;
  assign occupied   = r_occupied;

  // Node-flag lookup; index bits above LEVEL are masked off.
  always_comb begin
    w_occ_onehot = '0;
    for (int i = 0; i < NODES; i++) begin
      if ((r_addr & NODE_MASK) == ADDR_WIDTH'(i)) begin
        w_occ_onehot[i] = 1'b1;
      end else begin
        w_occ_onehot[i] = 1'b0;
      end
    end
    w_occ_hit = |(w_occ_onehot & r_occupied);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus the CMP-cycle write/forward decision.
  always_comb begin
    w_state_next = r_state;
    w_we         = 1'b0;
    w_fwd        = 1'b0;
    w_set_occ    = 1'b0;
    w_fwd_data   = r_data;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_next = READ;
        end else begin
          w_state_next = IDLE;
        end
      end
      READ: begin
        w_state_next = CMP;
      end
      CMP: begin
        if (!w_occ_hit) begin
          w_we         = 1'b1;
          w_set_occ    = 1'b1;
          w_state_next = IDLE;
        end else if (heap_before(HEAP_CMP_WIDTH'(r_data), HEAP_CMP_WIDTH'(ram_q_a))) begin
          w_we         = 1'b1;
          w_fwd        = 1'b1;
          w_fwd_data   = ram_q_a;
          w_state_next = SEND;
        end else begin
          w_fwd        = 1'b1;
          w_state_next = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = SEND;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Token latch; the RAM address is held from READ through CMP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data     <= '0;
      r_addr     <= '0;
      r_path     <= '0;
      r_ram_addr <= '0;
    end else if (w_accept) begin
      r_data     <= in_data;
      r_addr     <= in_addr;
      r_path     <= in_path;
      r_ram_addr <= in_addr;
    end
  end

  // Outgoing token: child index takes the next path bit, path shifts up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_out_path  <= '0;
    end else if (w_fwd) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_fwd_data;
      r_out_addr  <= {r_addr[ADDR_WIDTH-2:0], r_path[PATH_WIDTH-1]};
      r_out_path  <= {r_path[PATH_WIDTH-2:0], 1'b0};
    end else if ((r_state == SEND) && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Per-node valid flags; only a write into an empty node sets one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occupied <= '0;
    end else if (w_set_occ) begin
      r_occupied <= r_occupied | w_occ_onehot;
    end
  end

endmodule

// File: tb/tb_heap_insert_stage.sv
// Randomized self-checking bench for heap_insert_stage (LEVEL=1) with a behavioural
// level model and a registered-read RAM on port A.
module tb_heap_insert_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int PW = 5;
  localparam int LV = 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_data = '0;
  logic [AW-1:0]   in_addr = '0;
  logic [PW-1:0]   in_path = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_data;
  logic [AW-1:0]   out_addr;
  logic [PW-1:0]   out_path;
  logic [AW-1:0]   ram_addr_a;
  logic            ram_we_a;
  logic [DW-1:0]   ram_data_a;
  logic [DW-1:0]   ram_q_a;
  logic [(1<<LV)-1:0] occupied;

  logic [DW-1:0]   mem [0:31];
  int unsigned     ref_val [0:31];
  bit              ref_occ [0:1];
  int              n_tests = 0;
  int              n_fail  = 0;

  heap_insert_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEVEL(LV), .PATH_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_addr(in_addr), .in_path(in_path),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr), .out_path(out_path),
    .ram_addr_a(ram_addr_a), .ram_we_a(ram_we_a), .ram_data_a(ram_data_a), .ram_q_a(ram_q_a),
    .occupied(occupied)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
  end

  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
    ram_q_a <= mem[ram_addr_a];
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_before(input int unsigned a, input int unsigned b);
`ifdef HEAP_MAX_EN
    return a > b;
`else
    return a < b;
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ref_occ[0] = 1'b0; ref_occ[1] = 1'b0;
  endtask

  // One insert, checked cycle by cycle; must be called at a negedge while idle.
  task automatic run_token(input int unsigned d, input int unsigned a, input int unsigned p, input int stall);
    bit          occ, exp_we, exp_fwd;
    int unsigned exp_fdata, exp_oaddr, exp_opath;
    occ       = ref_occ[a % 2];
    exp_we    = !occ || model_before(d, ref_val[a]);
    exp_fwd   = occ;
    exp_fdata = (occ && model_before(d, ref_val[a])) ? ref_val[a] : d;
    exp_oaddr = (a * 2 + p / 16) % 32;
    exp_opath = (p * 2) % 32;

    check_eq("idle_in_ready", 64'(in_ready), 64'(1));
    in_valid = 1'b1; in_data = DW'(d); in_addr = AW'(a); in_path = PW'(p);
    @(negedge clk);
    in_valid = 1'b0; in_data = $urandom; in_addr = AW'($urandom); in_path = PW'($urandom);
    check_eq("read_we", 64'(ram_we_a), 64'(0));
    check_eq("read_addr", 64'(ram_addr_a), 64'(a));
    check_eq("read_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    check_eq("cmp_we", 64'(ram_we_a), 64'(exp_we));
    if (exp_we) check_eq("cmp_wdata", 64'(ram_data_a), 64'(d));
    check_eq("cmp_addr", 64'(ram_addr_a), 64'(a));
    check_eq("cmp_out_valid", 64'(out_valid), 64'(0));
    if (exp_we) ref_val[a] = d;
    ref_occ[a % 2] = 1'b1;
    @(negedge clk);
    if (exp_fwd) begin
      for (int k = 0; k <= stall; k++) begin
        check_eq("send_valid", 64'(out_valid), 64'(1));
        check_eq("send_data", 64'(out_data), 64'(exp_fdata));
        check_eq("send_addr", 64'(out_addr), 64'(exp_oaddr));
        check_eq("send_path", 64'(out_path), 64'(exp_opath));
        check_eq("send_in_ready", 64'(in_ready), 64'(0));
        check_eq("send_we", 64'(ram_we_a), 64'(0));
        if (k == stall) out_ready = 1'b1;
        @(negedge clk);
      end
      out_ready = 1'b0;
      check_eq("post_valid", 64'(out_valid), 64'(0));
    end else begin
      check_eq("nofwd_valid", 64'(out_valid), 64'(0));
    end
    check_eq("post_in_ready", 64'(in_ready), 64'(1));
    check_eq("occupied", 64'(occupied), 64'({ref_occ[1], ref_occ[0]}));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_val[i] = 0;
    do_reset();
    check_eq("rst_in_ready", 64'(in_ready), 64'(1));
    check_eq("rst_out_valid", 64'(out_valid), 64'(0));
    check_eq("rst_out_data", 64'(out_data), 64'(0));
    check_eq("rst_out_addr", 64'(out_addr), 64'(0));
    check_eq("rst_out_path", 64'(out_path), 64'(0));
    check_eq("rst_ram_addr", 64'(ram_addr_a), 64'(0));
    check_eq("rst_ram_we", 64'(ram_we_a), 64'(0));
    check_eq("rst_ram_data", 64'(ram_data_a), 64'(0));
    check_eq("rst_occupied", 64'(occupied), 64'(0));

    run_token(7, 1, 0, 0);
    check_eq("empty_insert_occ", 64'(occupied), 64'(2'b10));
    check_eq("empty_insert_mem", 64'(mem[1]), 64'(7));

    do_reset();
    run_token(5, 0, 0, 0);
    run_token(3, 0, 5'b10000, 0);
    do_reset();
    run_token(5, 0, 0, 0);
    run_token(5, 0, 0, 0);
    run_token(9, 0, 5'b01010, 4);
    do_reset();
    run_token(5, 0, 0, 0);
    run_token(8, 0, 5'b11111, 1);
    check_eq("node0_mem", 64'(mem[0]), 64'(ref_val[0]));

    // Reset in CMP while a write is pending.
    do_reset();
    in_valid = 1'b1; in_data = 32'd11; in_addr = 5'd0; in_path = 5'd0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("midrst_we_before", 64'(ram_we_a), 64'(1));
    rst_n = 1'b0;
    #1;
    check_eq("midrst_we", 64'(ram_we_a), 64'(0));
    check_eq("midrst_occ", 64'(occupied), 64'(0));
    check_eq("midrst_out_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    ref_occ[0] = 1'b0; ref_occ[1] = 1'b0;
    check_eq("midrst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    check_eq("midrst_mem_kept", 64'(mem[0]), 64'(ref_val[0]));

    for (int t = 0; t < 80; t++) begin
      run_token($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 31),
                int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
